pipeline_run_ctrl: RTL and testbench
====================================

PIPELINE_RUN_CTRL -- requirements
Module: pipeline_run_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the cycle, retire and run-length counters.
REQ-002 Parameter START_DELAY, default 64, number of idle cycles between start acceptance and the go pulse.
REQ-003 Parameter WD_LIMIT, default 1024, number of consecutive enabled cycles without a retire that flags a stuck pipeline.
REQ-004 clk  in  1  single system clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a run; latches mode and run_cycles.
REQ-007 mode  in  2  0 = FREE, 1 = STEP, 2 = RUN_N, 3 = reserved (treated as FREE).
REQ-008 run_cycles  in  CNT_W  enabled-cycle budget for RUN_N.
REQ-009 step  in  1  STEP mode: request one enabled pipeline cycle.
REQ-010 halt  in  1  abort the current run.
REQ-011 retire  in  1  pipeline reports one instruction retired in writeback this cycle.
REQ-012 go  out  1  one-cycle pulse to the pipeline marking run start.
REQ-013 cpu_en  out  1  pipeline clock enable.
REQ-014 busy  out  1  high in DELAY and RUN.
REQ-015 done  out  1  high in DONE.
REQ-016 stuck  out  1  high in STUCK.
REQ-017 cycle_count  out  CNT_W  enabled cycles in the current run; saturating.
REQ-018 retire_count  out  CNT_W  retires seen while cpu_en was high in the current run; saturating.

Function
REQ-019 States SHALL be IDLE, DELAY, RUN, DONE and STUCK.
REQ-020 In IDLE, DONE or STUCK, start SHALL latch mode and run_cycles, clear both counters and the watchdog, and enter DELAY; if START_DELAY = 0 it enters RUN directly.
REQ-021 start SHALL be ignored in DELAY and RUN.
REQ-022 DELAY SHALL last exactly START_DELAY cycles, then enter RUN; go SHALL be high only on the first RUN cycle.
REQ-023 In RUN, cpu_en SHALL be 1 every cycle for FREE and RUN_N, and in STEP SHALL be 1 only in the cycle after a step pulse (one enabled cycle per pulse).
REQ-024 RUN_N SHALL enter DONE on the edge at which cycle_count reaches run_cycles, so exactly run_cycles enabled cycles occur; run_cycles = 0 SHALL enter DONE after the go cycle with no cpu_en.
REQ-025 halt in DELAY or RUN SHALL enter DONE on the next edge with cpu_en low in that cycle; halt wins over a simultaneous step.
REQ-026 The watchdog SHALL count enabled cycles without retire, clear on any retire, and on reaching WD_LIMIT enter STUCK with cpu_en low; halt in the same cycle wins (DONE).
REQ-027 cycle_count and retire_count SHALL hold at 2^CNT_W-1 and never wrap; both hold their value in DONE and STUCK.
REQ-028 retire while cpu_en is low SHALL be ignored.
REQ-029 Outputs SHALL be registered, except that cpu_en and go are decoded from the registered state only.

Reset
REQ-030 On reset the state SHALL be IDLE, with go, cpu_en, busy, done and stuck all 0, both counters 0, the watchdog 0 and the latched mode FREE.
REQ-031 Reset asserted mid-run SHALL take priority over every input and abort the run with no further cpu_en.

Structure
REQ-032 The state enum, the mode enum and the mode encodings SHALL live in the shared package pipeline_ctrl_pkg.
REQ-033 One sub-module, sat_counter (parametrised width, clear, enable, saturating), SHALL be instantiated for cycle_count, retire_count and the watchdog.

Verification
REQ-034 Reset, then start with FREE and START_DELAY = 64 -> busy after 1 cycle, go pulses on cycle 65, cpu_en stays high.
REQ-035 RUN_N with run_cycles = 10 and retire every cycle -> exactly 10 cpu_en cycles, then done = 1, cycle_count = 10, retire_count = 10.
REQ-036 STEP mode with 3 step pulses spaced 4 cycles apart, then halt -> exactly 3 cpu_en cycles, cycle_count = 3, done = 1.
REQ-037 FREE with WD_LIMIT = 8 and no retire -> stuck after 8 enabled cycles, cpu_en low; a new start clears counters and re-enters DELAY.
REQ-038 CNT_W = 4, FREE for 20 cycles -> cycle_count saturates at 15; halt and step in the same cycle -> DONE with no enable.
REQ-039 Reset in the middle of RUN_N -> next cycle IDLE, all outputs 0; start during DELAY ignored.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline run controller.
// State/mode enums, mode encodings and a mode decode helper.
package pipeline_ctrl_pkg;

  localparam logic [1:0] MODE_ENC_FREE = 2'd0;
  localparam logic [1:0] MODE_ENC_STEP = 2'd1;
  localparam logic [1:0] MODE_ENC_RUNN = 2'd2;
  localparam logic [1:0] MODE_ENC_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_STUCK = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_FREE = MODE_ENC_FREE,
    MODE_STEP = MODE_ENC_STEP,
    MODE_RUNN = MODE_ENC_RUNN,
    MODE_RSVD = MODE_ENC_RSVD
  } mode_e;

  // Reserved encoding runs as FREE.
  function automatic mode_e decode_mode(
    input logic [1:0] m
  );
    mode_e r;
    r = MODE_FREE;
    unique case (m)
      MODE_ENC_STEP: r = MODE_STEP;
      MODE_ENC_RUNN: r = MODE_RUNN;
      default:       r = MODE_FREE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Saturating up-counter: clr wins over en, holds at all-ones.
// Ports: clk, reset (sync, high), clr, en, q.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run controller: start delay, FREE/STEP/RUN_N gating, halt, watchdog.
// In: clk reset start mode run_cycles step halt retire. Out: go cpu_en busy done stuck cycle_count retire_count.
module pipeline_run_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int START_DELAY = 64,
  parameter int WD_LIMIT    = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             step,
  input  logic             halt,
  input  logic             retire,
  output logic             go,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic             stuck,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  localparam int DLY_W =
    (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int WD_W0 = $clog2(WD_LIMIT + 1);
  localparam int WD_W  = (WD_W0 > 0) ? WD_W0 : 1;

  localparam logic [DLY_W-1:0] DLY_LAST =
    DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((WD_LIMIT > 0) ? WD_LIMIT - 1 : 0);

  state_e           state;
  mode_e            mode_q;
  logic [CNT_W-1:0] run_n;
  logic [DLY_W-1:0] dly;
  logic             first;
  logic             step_pend;
  logic [WD_W-1:0]  wd;

  logic start_ok;
  logic wd_hit;
  logic runn_hit;
  logic ret_en;

  assign start_ok = start &&
    ((state == ST_IDLE) || (state == ST_DONE) ||
     (state == ST_STUCK));

  assign go = (state == ST_RUN) && first;

  // Enable comes only from registered state so the
  // pipeline never sees a combinational path from inputs.
  always_comb begin
    cpu_en = 1'b0;
    if (state == ST_RUN) begin
      unique case (mode_q)
        MODE_STEP: cpu_en = step_pend;
        MODE_RUNN: cpu_en = (run_n != '0);
        default:   cpu_en = 1'b1;
      endcase
    end
  end

  assign ret_en = cpu_en && retire;

  assign wd_hit = (WD_LIMIT > 0) && cpu_en &&
    !retire && (wd == WD_LAST);

  // The edge that brings cycle_count up to run_n ends
  // the run; a zero budget ends after the go cycle.
  assign runn_hit = (mode_q == MODE_RUNN) &&
    ((run_n == '0) ||
     (cycle_count == run_n - CNT_W'(1)));

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (cpu_en),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_ret (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (ret_en),
    .q     (retire_count)
  );

  sat_counter #(.W(WD_W)) u_wd (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok || ret_en),
    .en    (cpu_en && !retire),
    .q     (wd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_FREE;
      run_n     <= '0;
      dly       <= '0;
      first     <= 1'b0;
      step_pend <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stuck     <= 1'b0;
    end else begin
      first     <= 1'b0;
      step_pend <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_STUCK: begin
          if (start) begin
            mode_q <= decode_mode(mode);
            run_n  <= run_cycles;
            dly    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
            stuck  <= 1'b0;
            if (START_DELAY == 0) begin
              state <= ST_RUN;
              first <= 1'b1;
            end else begin
              state <= ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (halt) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (dly == DLY_LAST) begin
            state <= ST_RUN;
            first <= 1'b1;
          end else begin
            dly <= dly + DLY_W'(1);
          end
        end
        ST_RUN: begin
          if (halt) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (wd_hit) begin
            state <= ST_STUCK;
            busy  <= 1'b0;
            stuck <= 1'b1;
          end else if (runn_hit) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (mode_q == MODE_STEP) begin
            step_pend <= step;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          stuck <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl.
// Instance a: default widths, delay 64, watchdog 8; b: 4-bit counters, delay 2.
module tb_pipeline_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] run_cycles = 16'd0;
  logic        step = 1'b0;
  logic        halt = 1'b0;
  logic        retire = 1'b0;

  logic        a_go, a_en, a_busy, a_done, a_stuck;
  logic [15:0] a_cyc, a_ret;
  logic        b_go, b_en, b_busy, b_done, b_stuck;
  logic [3:0]  b_cyc, b_ret;

  int n_assert = 0;
  int n_fail = 0;
  int ens;
  int gos;

  always #5 clk = ~clk;

  pipeline_run_ctrl #(
    .CNT_W(16), .START_DELAY(64), .WD_LIMIT(8)
  ) u_a (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .run_cycles   (run_cycles),
    .step         (step),
    .halt         (halt),
    .retire       (retire),
    .go           (a_go),
    .cpu_en       (a_en),
    .busy         (a_busy),
    .done         (a_done),
    .stuck        (a_stuck),
    .cycle_count  (a_cyc),
    .retire_count (a_ret)
  );

  pipeline_run_ctrl #(
    .CNT_W(4), .START_DELAY(2), .WD_LIMIT(1024)
  ) u_b (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .run_cycles   (run_cycles[3:0]),
    .step         (step),
    .halt         (halt),
    .retire       (retire),
    .go           (b_go),
    .cpu_en       (b_en),
    .busy         (b_busy),
    .done         (b_done),
    .stuck        (b_stuck),
    .cycle_count  (b_cyc),
    .retire_count (b_ret)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_go", 32'(a_go), 0);
    chk("rst_en", 32'(a_en), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_stuck", 32'(a_stuck), 0);
    chk("rst_cyc", 32'(a_cyc), 0);
    chk("rst_ret", 32'(a_ret), 0);

    // FREE with 64-cycle start delay
    start = 1'b1; mode = 2'd0; retire = 1'b1;
    tick();
    start = 1'b0;
    chk("d_busy", 32'(a_busy), 1);
    chk("d_go", 32'(a_go), 0);
    chk("d_en", 32'(a_en), 0);
    repeat (63) tick();
    chk("d63_go", 32'(a_go), 0);
    chk("d63_busy", 32'(a_busy), 1);
    tick();
    chk("go_pulse", 32'(a_go), 1);
    chk("go_en", 32'(a_en), 1);
    tick();
    chk("go_drop", 32'(a_go), 0);
    chk("free_en", 32'(a_en), 1);
    chk("free_cyc1", 32'(a_cyc), 1);
    repeat (5) tick();
    chk("free_en6", 32'(a_en), 1);
    chk("free_cyc6", 32'(a_cyc), 6);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_done", 32'(a_done), 1);
    chk("halt_busy", 32'(a_busy), 0);
    chk("halt_en", 32'(a_en), 0);

    // RUN_N 10 with retire every cycle
    start = 1'b1; mode = 2'd2; run_cycles = 16'd10;
    tick();
    start = 1'b0;
    ens = 0;
    for (int i = 0; i < 100; i++) begin
      ens += int'(a_en);
      tick();
    end
    chk("runn_ens", 32'(ens), 10);
    chk("runn_done", 32'(a_done), 1);
    chk("runn_cyc", 32'(a_cyc), 10);
    chk("runn_ret", 32'(a_ret), 10);

    // RUN_N with zero budget
    start = 1'b1; mode = 2'd2; run_cycles = 16'd0;
    tick();
    start = 1'b0;
    ens = 0; gos = 0;
    for (int i = 0; i < 80; i++) begin
      ens += int'(a_en);
      gos += int'(a_go);
      tick();
    end
    chk("run0_ens", 32'(ens), 0);
    chk("run0_gos", 32'(gos), 1);
    chk("run0_done", 32'(a_done), 1);
    chk("run0_cyc", 32'(a_cyc), 0);

    // STEP: three pulses four cycles apart, then halt
    retire = 1'b0;
    start = 1'b1; mode = 2'd1;
    tick();
    start = 1'b0;
    repeat (64) tick();
    chk("step_go", 32'(a_go), 1);
    ens = 0;
    for (int c = 0; c < 16; c++) begin
      step = (c % 4 == 0) && (c < 12);
      ens += int'(a_en);
      tick();
    end
    step = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("step_ens", 32'(ens), 3);
    chk("step_cyc", 32'(a_cyc), 3);
    chk("step_done", 32'(a_done), 1);

    // watchdog: FREE with no retire
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0;
    repeat (64) tick();
    ens = 0;
    for (int i = 0; i < 20; i++) begin
      ens += int'(a_en);
      tick();
    end
    chk("wd_ens", 32'(ens), 8);
    chk("wd_stuck", 32'(a_stuck), 1);
    chk("wd_en", 32'(a_en), 0);
    chk("wd_busy", 32'(a_busy), 0);
    chk("wd_cyc", 32'(a_cyc), 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("re_busy", 32'(a_busy), 1);
    chk("re_stuck", 32'(a_stuck), 0);
    chk("re_cyc", 32'(a_cyc), 0);
    chk("re_en", 32'(a_en), 0);

    // 4-bit saturation on instance b
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1; mode = 2'd0; retire = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("b_go", 32'(b_go), 1);
    repeat (20) tick();
    chk("sat_cyc", 32'(b_cyc), 15);
    chk("sat_ret", 32'(b_ret), 15);
    chk("sat_en", 32'(b_en), 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("sat_hold", 32'(b_cyc), 15);

    // halt beats step in the same cycle
    start = 1'b1; mode = 2'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    halt = 1'b1; step = 1'b1;
    tick();
    halt = 1'b0; step = 1'b0;
    chk("hs_done", 32'(b_done), 1);
    chk("hs_en", 32'(b_en), 0);
    tick();
    chk("hs_en2", 32'(b_en), 0);
    chk("hs_cyc", 32'(b_cyc), 0);

    // start in DELAY ignored, then reset mid RUN_N
    start = 1'b1; mode = 2'd2; run_cycles = 16'd10;
    tick();
    mode = 2'd0; run_cycles = 16'd3;
    tick();
    start = 1'b0;
    chk("ign_busy", 32'(b_busy), 1);
    chk("ign_go0", 32'(b_go), 0);
    tick();
    chk("ign_go", 32'(b_go), 1);
    repeat (5) tick();
    chk("mid_cyc", 32'(b_cyc), 5);
    chk("mid_busy", 32'(b_busy), 1);
    reset = 1'b1;
    tick();
    chk("mr_en", 32'(b_en), 0);
    chk("mr_busy", 32'(b_busy), 0);
    chk("mr_done", 32'(b_done), 0);
    chk("mr_go", 32'(b_go), 0);
    chk("mr_cyc", 32'(b_cyc), 0);
    chk("mr_ret", 32'(b_ret), 0);
    reset = 1'b0;
    tick();
    chk("mr_en2", 32'(b_en), 0);
    chk("mr_busy2", 32'(b_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
